cm_shr_arb: RTL and testbench

Round-robin arbiter that shares one fixed-latency delay line (a `cm_shr` instance) between `NREQ` requesters. Each cycle at most one requester's word enters the line, tagged with its requester index. After exactly `LEN` cycles the word leaves with its tag, and a per-requester valid strobe routes it back. A flush sequencer stops admission and drains the line on demand. The block sits in front of shared fixed-latency resources: delay-matched side paths, pipelined lookups and retiming stages.

---
 rtl/cm_pkg.sv | 16 +
 rtl/cm_shr.sv | 40 ++++
 rtl/cm_shr_arb.sv | 172 +++++++++++++++++
 tb/tb_cm_shr_arb.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cm_pkg.sv
// Shared types for the cm_* common blocks: delay-line reset modes and arbiter states.
package cm_pkg;

    localparam int SHR_ARB_NREQ_MAX = 16;

    typedef enum logic {
        SHR_ARB_RUN,
        SHR_ARB_FLUSH
    } t_shr_arb_state;

    typedef enum logic {
        SHR_RST_NONE,
        SHR_RST_FULL
    } t_shr_rst_mode;

endpackage

// File: rtl/cm_shr.sv
// Fixed-latency delay line: LEN cycles, LEN==0 is a wire; no backpressure.
module cm_shr
    import cm_pkg::*;
#(
    parameter int            LEN      = 2,
    parameter type           DTYPE    = logic [7:0],
    parameter t_shr_rst_mode RST_MODE = SHR_RST_FULL
) (
    input  logic i_clk,
    input  logic i_rst,
    input  DTYPE i_data,
    output DTYPE o_data
);

    generate
        if (LEN == 0) begin : g_bypass
            logic unused_clk_rst;
            assign unused_clk_rst = i_clk ^ i_rst;
            assign o_data = i_data;
        end else begin : g_line
            DTYPE q_line [LEN];

            always_ff @(posedge i_clk) begin
                if (RST_MODE == SHR_RST_FULL && i_rst) begin
                    for (int i = 0; i < LEN; i++) begin
                        q_line[i] <= '0;
                    end
                end else begin
                    q_line[0] <= i_data;
                    for (int i = 1; i < LEN; i++) begin
                        q_line[i] <= q_line[i-1];
                    end
                end
            end

            assign o_data = q_line[LEN-1];
        end
    endgenerate

endmodule

// File: rtl/cm_shr_arb.sv
// Round-robin share of one LEN-cycle delay line among NREQ requesters; responses are never stalled.
// Optional CM_SHR_ARB_LOCK_EN: i_req_last keeps the grant on one requester for multi-beat packets.
module cm_shr_arb
    import cm_pkg::*;
#(
    parameter int  NREQ  = 4,
    parameter int  LEN   = 2,
    parameter type DTYPE = logic [7:0]
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [NREQ-1:0]              i_req_vld,
    input  logic [NREQ*$bits(DTYPE)-1:0] i_req_data,
    output logic [NREQ-1:0]              o_req_rdy,
    output logic [NREQ-1:0]              o_rsp_vld,
    output DTYPE                         o_rsp_data,
    output logic [$clog2(NREQ)-1:0]      o_rsp_id,
    input  logic                         i_flush,
`ifdef CM_SHR_ARB_LOCK_EN
    input  logic [NREQ-1:0]              i_req_last,
`endif
    output logic                         o_flush_done,
    output logic                         o_busy
);

    localparam int IDW = $clog2(NREQ);
    localparam int DW  = $bits(DTYPE);
    localparam int OW  = (LEN > 0) ? $clog2(LEN + 1) : 1;

    typedef struct packed {
        logic           vld;
        logic [IDW-1:0] id;
        DTYPE           data;
    } t_ent;

    // Returns {found, index} of the first set bit at or above ptr, wrapping.
    function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] vld, input logic [IDW-1:0] ptr);
        logic [IDW:0] r;
        int           k;
        r = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            k = (int'(ptr) + i) % NREQ;
            if (vld[k]) r = {1'b1, IDW'(k)};
        end
        return r;
    endfunction

    t_shr_arb_state q_state, d_state;
    logic [7:0]     q_cnt, d_cnt;
    logic [IDW-1:0] q_ptr, d_ptr;
    logic [OW-1:0]  q_occ, d_occ;
    logic [NREQ-1:0] cand;
    logic [IDW:0]   pick;
    logic [IDW-1:0] win;
    logic           xfer;
    logic           flush_go;
    t_ent           line_in, line_out;

`ifdef CM_SHR_ARB_LOCK_EN
    logic           q_lock, d_lock;
    logic [IDW-1:0] q_lock_id, d_lock_id;
    logic           q_pend, d_pend;
`endif

    always_comb begin
        cand = i_req_vld;
`ifdef CM_SHR_ARB_LOCK_EN
        if (q_lock) cand = i_req_vld & (NREQ'(1) << q_lock_id);
`endif
        pick = rr_pick(cand, q_ptr);
        win  = pick[IDW-1:0];
        xfer = (q_state == SHR_ARB_RUN) && pick[IDW];

        o_req_rdy = '0;
        if (xfer) o_req_rdy = NREQ'(1) << win;

        line_in = '0;
        if (xfer) begin
            line_in.vld  = 1'b1;
            line_in.id   = win;
            line_in.data = DTYPE'(i_req_data[win*DW +: DW]);
        end
    end

    always_comb begin
        d_state      = q_state;
        d_cnt        = q_cnt;
        d_ptr        = q_ptr;
        o_flush_done = 1'b0;
        flush_go     = i_flush;

        if (xfer) d_ptr = (win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1);

`ifdef CM_SHR_ARB_LOCK_EN
        d_lock    = q_lock;
        d_lock_id = q_lock_id;
        if (xfer) begin
            d_lock    = ~i_req_last[win];
            d_lock_id = win;
        end
        // A pulsed flush is remembered until the packet in progress has closed.
        flush_go = (i_flush | q_pend) & ~d_lock;
        d_pend   = (q_state == SHR_ARB_RUN) & (i_flush | q_pend) & d_lock;
`endif

        case (q_state)
            SHR_ARB_RUN: begin
                if (flush_go) begin
                    d_state = SHR_ARB_FLUSH;
                    d_cnt   = 8'(LEN);
                end
            end
            SHR_ARB_FLUSH: begin
                d_cnt = (q_cnt == 8'd0) ? 8'd0 : q_cnt - 8'd1;
                if (q_cnt <= 8'd1) begin
                    o_flush_done = 1'b1;
                    d_state      = SHR_ARB_RUN;
                end
            end
            default: d_state = SHR_ARB_RUN;
        endcase

        d_occ = q_occ;
        if (line_in.vld && !line_out.vld) d_occ = q_occ + OW'(1);
        else if (!line_in.vld && line_out.vld) d_occ = q_occ - OW'(1);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            q_state <= SHR_ARB_RUN;
            q_cnt   <= '0;
            q_ptr   <= '0;
            q_occ   <= '0;
        end else begin
            q_state <= d_state;
            q_cnt   <= d_cnt;
            q_ptr   <= d_ptr;
            q_occ   <= d_occ;
        end
    end

`ifdef CM_SHR_ARB_LOCK_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            q_lock    <= 1'b0;
            q_lock_id <= '0;
            q_pend    <= 1'b0;
        end else begin
            q_lock    <= d_lock;
            q_lock_id <= d_lock_id;
            q_pend    <= d_pend;
        end
    end
`endif

    cm_shr #(
        .LEN      (LEN),
        .DTYPE    (t_ent),
        .RST_MODE (SHR_RST_FULL)
    ) u_shr (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_data (line_in),
        .o_data (line_out)
    );

    assign o_rsp_vld  = line_out.vld ? (NREQ'(1) << line_out.id) : '0;
    assign o_rsp_data = line_out.vld ? line_out.data : '0;
    assign o_rsp_id   = line_out.vld ? line_out.id : '0;
    assign o_busy     = (q_occ != '0);

endmodule

// File: tb/tb_cm_shr_arb.sv
// Bench for cm_shr_arb: LEN=3 main instance with response scoreboard, plus LEN=4 and LEN=0 instances.
module tb_cm_shr_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Main instance, LEN=3
    logic        rst, flush, done, busy;
    logic [3:0]  vld, rdy, rsp_vld;
    logic [31:0] data;
    logic [7:0]  rsp_data;
    logic [1:0]  rsp_id;
`ifdef CM_SHR_ARB_LOCK_EN
    logic [3:0]  last;
`endif

    cm_shr_arb #(.NREQ(4), .LEN(3)) u_dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req_vld    (vld),
        .i_req_data   (data),
        .o_req_rdy    (rdy),
        .o_rsp_vld    (rsp_vld),
        .o_rsp_data   (rsp_data),
        .o_rsp_id     (rsp_id),
        .i_flush      (flush),
`ifdef CM_SHR_ARB_LOCK_EN
        .i_req_last   (last),
`endif
        .o_flush_done (done),
        .o_busy       (busy)
    );

    // LEN=4 instance for the mid-operation reset case
    logic        rst4, flush4, done4, busy4;
    logic [3:0]  vld4, rdy4, rsp_vld4;
    logic [31:0] data4;
    logic [7:0]  rsp_data4;
    logic [1:0]  rsp_id4;

    cm_shr_arb #(.NREQ(4), .LEN(4)) u_dut4 (
        .i_clk        (clk),
        .i_rst        (rst4),
        .i_req_vld    (vld4),
        .i_req_data   (data4),
        .o_req_rdy    (rdy4),
        .o_rsp_vld    (rsp_vld4),
        .o_rsp_data   (rsp_data4),
        .o_rsp_id     (rsp_id4),
        .i_flush      (flush4),
`ifdef CM_SHR_ARB_LOCK_EN
        .i_req_last   (4'b1111),
`endif
        .o_flush_done (done4),
        .o_busy       (busy4)
    );

    // LEN=0 bypass instance
    logic        rst0, flush0, done0, busy0;
    logic [3:0]  vld0, rdy0, rsp_vld0;
    logic [31:0] data0;
    logic [7:0]  rsp_data0;
    logic [1:0]  rsp_id0;

    cm_shr_arb #(.NREQ(4), .LEN(0)) u_dut0 (
        .i_clk        (clk),
        .i_rst        (rst0),
        .i_req_vld    (vld0),
        .i_req_data   (data0),
        .o_req_rdy    (rdy0),
        .o_rsp_vld    (rsp_vld0),
        .o_rsp_data   (rsp_data0),
        .o_rsp_id     (rsp_id0),
        .i_flush      (flush0),
`ifdef CM_SHR_ARB_LOCK_EN
        .i_req_last   (4'b1111),
`endif
        .o_flush_done (done0),
        .o_busy       (busy0)
    );

    typedef struct {
        int         due;
        logic [1:0] id;
        logic [7:0] dat;
    } exp_t;

    typedef struct {
        logic [3:0] vld;
        logic [3:0] rdy;
    } vec_t;

    exp_t sb[$];
    int   beat[4];
    vec_t tv[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_data();
        for (int i = 0; i < 4; i++) data[8*i +: 8] = 8'(16 * i + beat[i]);
    endtask

    // One cycle of the main instance: check grant, busy, done and responses, then record transfers.
    task automatic tick(input logic [3:0] exp_rdy, input logic exp_done);
        exp_t e;
        #2;
        chk("grant", 32'(rdy), 32'(exp_rdy));
        chk("flush_done", 32'(done), 32'(exp_done));
        chk("busy", 32'(busy), 32'(sb.size() > 0));
        if (rsp_vld != 4'b0) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 32'(rsp_vld), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("rsp_latency", cyc, e.due);
                chk("rsp_vld", 32'(rsp_vld), 32'(4'b0001 << e.id));
                chk("rsp_id", 32'(rsp_id), 32'(e.id));
                chk("rsp_data", 32'(rsp_data), 32'(e.dat));
            end
        end else if (sb.size() > 0 && sb[0].due <= cyc) begin
            chk("rsp_missing", 32'(rsp_vld), 32'(4'b0001 << sb[0].id));
            void'(sb.pop_front());
        end
        for (int i = 0; i < 4; i++) begin
            if (vld[i] && rdy[i]) begin
                e.due = cyc + 3;
                e.id  = 2'(i);
                e.dat = data[8*i +: 8];
                sb.push_back(e);
                beat[i]++;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        for (int k = 0; k < 8; k++) tv[k] = '{4'b1111, 4'b0001 << (k % 4)};
        for (int k = 8; k < 13; k++) tv[k] = '{4'b0100, 4'b0100};
        tv[13] = '{4'b1010, 4'b1000};
        tv[14] = '{4'b1010, 4'b0010};
        tv[15] = '{4'b0000, 4'b0000};

        rst = 1'b1; rst4 = 1'b1; rst0 = 1'b1;
        flush = 1'b0; flush4 = 1'b0; flush0 = 1'b0;
        vld = 4'b0110; vld4 = 4'b0; vld0 = 4'b0;
        data = '0; data4 = '0; data0 = '0;
`ifdef CM_SHR_ARB_LOCK_EN
        last = 4'b1111;
`endif
        for (int i = 0; i < 4; i++) beat[i] = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2;
        chk("reset_rdy", 32'(rdy), 32'(4'b0010));
        chk("reset_rsp_vld", 32'(rsp_vld), 32'd0);
        chk("reset_rsp_data", 32'(rsp_data), 32'd0);
        chk("reset_rsp_id", 32'(rsp_id), 32'd0);
        chk("reset_flush_done", 32'(done), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        vld = 4'b0;
        rst = 1'b0; rst4 = 1'b0; rst0 = 1'b0;
        @(posedge clk); #1;

        // Rotation, single requester, pointer resume
        for (int k = 0; k < 16; k++) begin
            vld = tv[k].vld;
            set_data();
            tick(tv[k].rdy, 1'b0);
        end
        vld = 4'b0;
        for (int k = 0; k < 4; k++) tick(4'b0, 1'b0);

        // Flush with three beats in flight; pointer starts at 2
        vld = 4'b1111;
        set_data(); tick(4'b0100, 1'b0);
        set_data(); tick(4'b1000, 1'b0);
        flush = 1'b1;
        set_data(); tick(4'b0001, 1'b0);
        flush = 1'b0;
        set_data(); tick(4'b0000, 1'b0);
        set_data(); tick(4'b0000, 1'b0);
        set_data(); tick(4'b0000, 1'b1);
        set_data(); tick(4'b0010, 1'b0);
        vld = 4'b0;
        for (int k = 0; k < 4; k++) tick(4'b0, 1'b0);

        // LEN=4: fill, then reset with the line full
        vld4 = 4'b1111;
        data4 = 32'hD3C2B1A0;
        for (int k = 0; k < 4; k++) begin @(posedge clk); #1; end
        #2;
        chk("len4_first_rsp", 32'(rsp_vld4), 32'(4'b0001));
        chk("len4_first_data", 32'(rsp_data4), 32'hA0);
        chk("len4_busy_full", 32'(busy4), 32'd1);
        vld4 = 4'b0;
        rst4 = 1'b1;
        @(posedge clk); #1;
        rst4 = 1'b0;
        #2;
        chk("len4_rst_rsp_vld", 32'(rsp_vld4), 32'd0);
        chk("len4_rst_busy", 32'(busy4), 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #3;
            chk("len4_no_stale", 32'(rsp_vld4), 32'd0);
        end

        // LEN=0: same-cycle response
        vld0 = 4'b0010;
        data0 = 32'h3C00A500;
        #2;
        chk("len0_rdy", 32'(rdy0), 32'(4'b0010));
        chk("len0_rsp_vld", 32'(rsp_vld0), 32'(4'b0010));
        chk("len0_rsp_data", 32'(rsp_data0), 32'hA5);
        chk("len0_rsp_id", 32'(rsp_id0), 32'd1);
        chk("len0_busy", 32'(busy0), 32'd0);
        @(posedge clk); #1;
        vld0 = 4'b1001;
        #2;
        chk("len0_rsp_vld_ptr", 32'(rsp_vld0), 32'(4'b1000));
        chk("len0_rsp_data_ptr", 32'(rsp_data0), 32'h3C);
        chk("len0_rsp_id_ptr", 32'(rsp_id0), 32'd3);
        @(posedge clk); #1;
        vld0 = 4'b0;

`ifdef CM_SHR_ARB_LOCK_EN
        // Three-beat packet from requester 0 holds off requester 1
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        for (int i = 0; i < 4; i++) beat[i] = 0;
        vld = 4'b0011;
        for (int k = 0; k < 4; k++) begin
            last = {3'b111, (beat[0] == 2)};
            set_data();
            tick((k < 3) ? 4'b0001 : 4'b0010, 1'b0);
        end
        vld = 4'b0;
        last = 4'b1111;
        for (int k = 0; k < 4; k++) tick(4'b0, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
